// File: rtl/ifetch_pfb_if.sv
// Bus bundles for the instruction prefetch buffer:
// memory-side read port and core-side fetch/redirect port.
interface ifetch_mem_if;
    logic        m_cs;
    logic        m_we;
    logic [31:0] m_addr;
    logic [3:0]  m_byte;
    logic [31:0] m_di;
    logic [31:0] m_do;
    logic        m_busy;
    logic        m_err;

    modport master (
        output m_cs, m_we, m_addr, m_byte, m_di,
        input  m_do, m_busy, m_err
    );
    modport slave (
        input  m_cs, m_we, m_addr, m_byte, m_di,
        output m_do, m_busy, m_err
    );
endinterface

interface ifetch_core_if;
    logic        redir;
    logic [31:0] redir_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_err;

    modport master (
        input  redir, redir_pc, out_ready,
        output out_valid, out_pc, out_inst, out_err
    );
    modport slave (
        output redir, redir_pc, out_ready,
        input  out_valid, out_pc, out_inst, out_err
    );
endinterface

// File: rtl/ifetch_pfb.sv
// Instruction prefetch buffer: sequential word reads queued as
// {pc, inst, err} in a small FIFO, with redirect and error halt.
module ifetch_pfb #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic           clk,
    input logic           rstn,
    ifetch_core_if.master core,
    ifetch_mem_if.master  mem
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic          run_q, run_d;
    logic [31:0]   fetch_q, fetch_d;
    logic          hold_q, hold_d;
    logic [31:0]   hold_addr_q, hold_addr_d;
    logic [31:0]   rsp_addr_q, rsp_addr_d;
    logic          inflight_q, inflight_d;
    logic          drop_q, drop_d;
    logic          halted_q, halted_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   pc_q [DEPTH];
    logic [31:0]   pc_d [DEPTH];
    logic [31:0]   inst_q [DEPTH];
    logic [31:0]   inst_d [DEPTH];
    logic          err_q [DEPTH];
    logic          err_d [DEPTH];

    logic        credit;
    logic        cs;
    logic        accept;
    logic        push;
    logic        pop;
    logic [31:0] addr;

    // A stalled request keeps its address even across a redirect.
    assign credit = (cnt_q + CW'(inflight_q)) < CW'(DEPTH);
    assign cs     = run_q && (hold_q || (!halted_q && credit));
    assign addr   = hold_q ? hold_addr_q : fetch_q;
    assign accept = cs && !mem.m_busy;
    assign push   = inflight_q && !drop_q && !core.redir;
    assign pop    = (cnt_q != '0) && core.out_ready && !core.redir;

    assign mem.m_cs   = cs;
    assign mem.m_we   = 1'b0;
    assign mem.m_addr = addr;
    assign mem.m_byte = 4'hf;
    assign mem.m_di   = 32'h0;

    assign core.out_valid = (cnt_q != '0);
    assign core.out_pc    = pc_q[rd_q];
    assign core.out_inst  = inst_q[rd_q];
    assign core.out_err   = err_q[rd_q];

    always_comb begin
        run_d       = 1'b1;
        hold_d      = cs && mem.m_busy;
        hold_addr_d = addr;
        fetch_d     = fetch_q;
        rsp_addr_d  = accept ? addr : rsp_addr_q;
        inflight_d  = accept;
        drop_d      = drop_q;
        halted_d    = halted_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        cnt_d       = cnt_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        err_d       = err_q;
        if (cs && !hold_q) fetch_d = fetch_q + 32'd4;
        if (inflight_q) drop_d = 1'b0;
        if (push) begin
            pc_d[wr_q]   = rsp_addr_q;
            inst_d[wr_q] = mem.m_do;
            err_d[wr_q]  = mem.m_err;
            wr_d         = wr_q + PW'(1);
            if (mem.m_err) halted_d = 1'b1;
        end
        if (pop) rd_d = rd_q + PW'(1);
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        if (core.redir) begin
            fetch_d  = core.redir_pc & ~32'h3;
            halted_d = 1'b0;
            rd_d     = '0;
            wr_d     = '0;
            cnt_d    = '0;
            if (cs) drop_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run_q       <= 1'b0;
            fetch_q     <= RESET_PC;
            hold_q      <= 1'b0;
            hold_addr_q <= 32'h0;
            rsp_addr_q  <= 32'h0;
            inflight_q  <= 1'b0;
            drop_q      <= 1'b0;
            halted_q    <= 1'b0;
            rd_q        <= '0;
            wr_q        <= '0;
            cnt_q       <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_q[i]   <= 32'h0;
                inst_q[i] <= 32'h0;
                err_q[i]  <= 1'b0;
            end
        end else begin
            run_q       <= run_d;
            fetch_q     <= fetch_d;
            hold_q      <= hold_d;
            hold_addr_q <= hold_addr_d;
            rsp_addr_q  <= rsp_addr_d;
            inflight_q  <= inflight_d;
            drop_q      <= drop_d;
            halted_q    <= halted_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            cnt_q       <= cnt_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            err_q       <= err_d;
        end
    end
endmodule
